ifetch_skid_buffer: RTL and testbench

Elastic 2-entry pipeline register between the instruction-fetch stage (producer) and decode (consumer). It carries 128-bit fetch bundles plus PC using a valid/ready handshake. It sustains 1 bundle/cycle, and registers in_ready so that back-pressure from decode never forms a combinational path into IFetch. It supports a synchronous flush for branch redirect.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_hold_reg.sv | 30 +++
 rtl/ifetch_skid_buffer.sv | 120 ++++++++++++
 tb/tb_ifetch_skid_buffer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and widths for the fetch-to-decode elastic buffer.
package ifetch_pkg;

  localparam int unsigned FETCH_W = 128;
  localparam int unsigned PC_W    = 32;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] data;
    logic [PC_W-1:0]    pc;
  } fetch_bundle_t;

endpackage

// File: rtl/ifetch_hold_reg.sv
// Bundle holding register: async reset, load enable, synchronous clear.
module ifetch_hold_reg
  import ifetch_pkg::*;
#(
  parameter int unsigned Width = FETCH_W + PC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] hold_q;

  // Clear wins over load so a flush drops a bundle arriving in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else if (clr_i) begin
      hold_q <= '0;
    end else if (load_i) begin
      hold_q <= d_i;
    end
  end

  assign q_o = hold_q;

endmodule

// File: rtl/ifetch_skid_buffer.sv
// Two-entry elastic buffer between IFetch and decode; all handshake outputs
// come from registers so decode back-pressure never reaches IFetch combinationally.
module ifetch_skid_buffer #(
  parameter int unsigned WIDTH = ifetch_pkg::FETCH_W,
  parameter int unsigned PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [PC_W-1:0]  out_pc,
  output logic [1:0]       occupancy
);

  import ifetch_pkg::*;

  localparam int unsigned BundleW = WIDTH + PC_W;

  skid_state_t        state_q, state_d;
  logic               rdy_q;
  logic               acc, take;
  logic               main_load, skid_load, use_skid;
  logic [BundleW-1:0] in_bundle, main_d, main_q, skid_q;

  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign in_bundle = {in_data, in_pc};
  assign main_d    = use_skid ? skid_q : in_bundle;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    use_skid  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (acc && take) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            main_load = 1'b1;
            use_skid  = 1'b1;
            state_d   = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // rdy_q stays low through reset and rises on the first edge afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != FULL);
    end
  end

  ifetch_hold_reg #(
    .Width(BundleW)
  ) u_main (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (flush),
    .load_i(main_load),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  ifetch_hold_reg #(
    .Width(BundleW)
  ) u_skid (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (flush),
    .load_i(skid_load),
    .d_i   (in_bundle),
    .q_o   (skid_q)
  );

  assign out_valid           = (state_q != EMPTY);
  assign in_ready            = rdy_q;
  assign {out_data, out_pc}  = main_q;

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_ifetch_skid_buffer.sv
// Bench for ifetch_skid_buffer: directed scenarios then random traffic against a queue model.
module tb_ifetch_skid_buffer;

  localparam int W = 128;
  localparam int P = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [P-1:0] in_pc, out_pc;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  ifetch_skid_buffer #(
    .WIDTH(W),
    .PC_W (P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_pc   (out_pc),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [P-1:0] pc;
  } ent_t;

  ent_t q[$];
  bit   rdy_m;
  bit   last_acc;
  int   total;
  int   bad;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO of capacity 2; ready is known only once the first edge after reset has passed.
  task automatic check_model();
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(rdy_m && q.size() < 2));
    chk("occupancy", W'(occupancy), W'(q.size()));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_pc", W'(out_pc), W'(q[0].pc));
    end
  endtask

  task automatic cycle();
    bit   take, acc;
    ent_t e;
    take = (q.size() > 0) && out_ready;
    acc  = in_valid && rdy_m && (q.size() < 2);
    @(posedge clk);
    if (take) e = q.pop_front();
    if (flush) q.delete();
    else if (acc) begin
      e.d  = in_data;
      e.pc = in_pc;
      q.push_back(e);
    end
    rdy_m    = 1'b1;
    last_acc = acc;
    #1;
    check_model();
  endtask

  task automatic send(input logic [W-1:0] d, input logic [P-1:0] pc);
    in_valid = 1'b1;
    in_data  = d;
    in_pc    = pc;
    cycle();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rdy_m     = 1'b0;
    last_acc  = 1'b0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 128'd25;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset held with a bundle presented
    #12;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occ", W'(occupancy), '0);
    chk("rst_in_ready", W'(in_ready), '0);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready_pre", W'(in_ready), '0);
    cycle();
    chk("rel_in_ready_post", W'(in_ready), W'(1));

    // Pass-through
    out_ready = 1'b1;
    send(128'd678, 32'h100);
    chk("pt_data", out_data, 128'd678);
    chk("pt_pc", W'(out_pc), W'(32'h100));
    chk("pt_occ1", W'(occupancy), W'(1));
    in_valid = 1'b0;
    cycle();
    chk("pt_occ0", W'(occupancy), '0);

    // Back-pressure then drain
    out_ready = 1'b0;
    send(128'd678, 32'h200);
    send(128'd123, 32'h204);
    chk("bp_occ", W'(occupancy), W'(2));
    chk("bp_ready", W'(in_ready), '0);
    chk("bp_data", out_data, 128'd678);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("bp_drain1", out_data, 128'd123);
    chk("bp_ready_back", W'(in_ready), W'(1));
    cycle();

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      send(W'(i), P'(32'h1000 + 4 * i));
      chk("stream_data", out_data, W'(i));
    end
    in_valid = 1'b0;
    cycle();

    // Flush while full, with a competing input
    out_ready = 1'b0;
    send(128'd678, 32'h300);
    send(128'd123, 32'h304);
    flush = 1'b1;
    send(128'd999, 32'h308);
    chk("fl_valid", W'(out_valid), '0);
    chk("fl_occ", W'(occupancy), '0);
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("fl_after", W'(out_valid), '0);

    // Async reset between edges while full
    send(128'd55, 32'h400);
    send(128'd66, 32'h404);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", W'(out_valid), '0);
    chk("ar_data", out_data, '0);
    chk("ar_occ", W'(occupancy), '0);
    q.delete();
    rdy_m = 1'b0;
    #2;
    rst = 1'b1;
    cycle();

    // Random traffic; a refused bundle is held until it is taken
    for (int n = 0; n < 400; n++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_pc    = $urandom;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
